bcd_clock_reminder: RTL and testbench
=====================================

# bcd_clock_reminder

Single-clock-domain, run-time configurable HH:MM:SS BCD clock for the water-reminder board. It takes the 50 MHz board clock, produces a one-cycle seconds tick from a fractional phase accumulator at one of four selectable rates, and advances six cascaded BCD digits. It can be loaded with a time, paused, and displayed in 12 h or 24 h form on six seven-segment displays. When compiled in, it raises a reminder after a programmable number of elapsed minutes.

## Interface
Parameters:
- ACC_W, 40: phase accumulator width in bits.
- INC_0, 21990: accumulator increment for speed 0 (1 tick/s at 50 MHz).
- INC_1, 1319414: increment for speed 1 (60 ticks/s).
- INC_2, 79164837: increment for speed 2 (3600 ticks/s).
- INC_3, 79164837: increment for speed 3.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- speed  in  2  selects INC_0..INC_3.
- run  in  1  1 = the accumulator advances; 0 = frozen, no ticks.
- hour24  in  1  display format: 1 = 24 h, 0 = 12 h.
- load  in  1  one-cycle pulse that loads load_bcd.
- load_bcd  in  24  {H1,H0,M1,M0,S1,S0}, 24 h BCD format.
- remind_min  in  8  reminder interval as two BCD digits, 01..99.
- remind_ack  in  1  pulse that clears the reminder.
- time_bcd  out  24  current time, always 24 h BCD.
- hex0..hex5  out  7 each  active-low segments {g..a}; hex0 = S0, hex5 = H1.
- pm  out  1  1 in 12 h mode when the internal hour is ≥ 12; always 0 in 24 h mode.
- tick  out  1  one-cycle pulse when the seconds advance.
- load_err  out  1  one-cycle pulse when load_bcd is rejected.
- remind  out  1  level; asserted when the interval elapses.

## Operation
- Tick generator: acc <= acc + INC[speed] while run = 1. tick is the registered carry out of bit ACC_W-1.
- A change to speed takes effect on the next add. acc is not cleared.
- Time is always held internally in 24 h form.
- Digit limits: S0 and M0 run 0-9; S1 and M1 run 0-5. Hours run 00-23: H0 wraps at 9, or at 3 when H1 = 2.
- Each tick increments S0 and ripples carries to higher digits. 23:59:59 becomes 00:00:00.
- Load: each nibble is checked against its digit limit, and hours must be ≤ 23.
  - Valid: the time registers take load_bcd.
  - Invalid: time is unchanged and load_err pulses.
  - load has priority over a same-cycle tick. That tick is lost.
- 12 h display is combinational from the internal hour:
  - 00 shows 12 with pm = 0.
  - 01-11 show unchanged with pm = 0.
  - 12 shows 12 with pm = 1.
  - 13-23 show hour-12 with pm = 1.
  - Switching hour24 changes only the display outputs, never the stored state.
- Reminder:
  - A BCD elapsed-minutes counter (00-99) increments on each minute rollover, i.e. a tick where S = 59.
  - When the counter equals remind_min, remind is set and the counter clears.
  - remind_ack clears both remind and the counter.
  - If ack and the match occur in the same cycle, ack wins.
  - A valid load also clears the counter and does not change remind.
  - remind_min = 00 disables the match.

## Timing
- Reset values: acc = 0, time = 00:00:00, tick = 0, load_err = 0, remind = 0, elapsed counter = 00.
- Display after reset in 24 h mode: all hex = 7'b1000000, pm = 0.
- A carry at edge N gives tick = 1 in cycle N+1, and time_bcd is updated at edge N+2. The latency is 1 cycle from tick to time.
- A load sampled at edge N gives time_bcd = load_bcd after edge N. load_err is high for the cycle following edge N.
- remind rises on the same edge as the minute rollover that produces the match. It falls on the edge after ack is sampled.
- hex, pm and time_bcd are combinational from registers. They are glitch-free with respect to hour24 only in the sense that no state changes.
- When reset is asserted mid-count, all state clears immediately. No tick is issued in the cycle after release.

## Configuration
- WATER_REMIND_EN defined: the reminder counter and compare are built as described under Operation.
- WATER_REMIND_EN undefined: remind is tied to 0, and remind_min and remind_ack are ignored. The ports remain so that wrappers are unchanged.

## Structure
- Package bcd_clock_pkg holds:
  - digit-limit constants,
  - the speed_t enum,
  - the seg7 function (hex 0-F to active-low segments),
  - the bcd_valid_time function.
- Sub-module bcd_tick_gen contains the accumulator and the tick register, parameterised by ACC_W and INC_0..3.
- The cascade, load check, 12 h mapping and reminder are in the top level.

## Test plan
All scenarios run with bench parameters ACC_W = 8, INC_0..3 = 128, so run = 1 gives a tick every 2 cycles.
- Reset release:
  - Required: time_bcd = 24'h000000, all hex = 7'b1000000, remind = 0.
  - After 10 cycles with run = 1: 5 ticks, time_bcd = 24'h000005.
- Load 24'h235958, then 2 ticks:
  - Required: 24'h235959, then 24'h000000. No load_err.
- 12 h display with hour24 = 0:
  - Load 24'h130500: hex5/hex4 show 0/1, pm = 1.
  - Load 24'h000000: hex5/hex4 show 1/2, pm = 0.
- Invalid loads 24'h250000 and 24'h006000:
  - Required: load_err = 1 for one cycle each, time_bcd unchanged.
- Load coincident with tick:
  - Required: time_bcd equals load_bcd exactly, no +1.
- With WATER_REMIND_EN, remind_min = 8'h02, start at 00:00:00:
  - remind = 0 through 00:01:59, and rises with 00:02:00.
  - remind_ack returns remind to 0 the next cycle.
  - The next assertion is at 00:04:00.

Source files
------------

// File: rtl/bcd_clock_pkg.sv
// Shared constants, speed encoding and helpers for the BCD clock with water reminder.
package bcd_clock_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned TIME_W  = 6 * DIGIT_W;

  localparam logic [DIGIT_W-1:0] S0_MAX     = 4'd9;
  localparam logic [DIGIT_W-1:0] S1_MAX     = 4'd5;
  localparam logic [DIGIT_W-1:0] M0_MAX     = 4'd9;
  localparam logic [DIGIT_W-1:0] M1_MAX     = 4'd5;
  localparam logic [DIGIT_W-1:0] H0_MAX     = 4'd9;
  localparam logic [DIGIT_W-1:0] H1_MAX     = 4'd2;
  localparam logic [DIGIT_W-1:0] H0_MAX_H20 = 4'd3;

  typedef enum logic [1:0] {
    SPEED_0 = 2'd0,
    SPEED_1 = 2'd1,
    SPEED_2 = 2'd2,
    SPEED_3 = 2'd3
  } speed_t;

  // Hex digit to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [DIGIT_W-1:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // {H1,H0,M1,M0,S1,S0} is a legal 24 h time.
  function automatic logic bcd_valid_time(input logic [TIME_W-1:0] t);
    logic [DIGIT_W-1:0] h1, h0, m1, m0, s1, s0;
    {h1, h0, m1, m0, s1, s0} = t;
    bcd_valid_time = (s0 <= S0_MAX) && (s1 <= S1_MAX) &&
                     (m0 <= M0_MAX) && (m1 <= M1_MAX) &&
                     (h0 <= H0_MAX) && (h1 <= H1_MAX) &&
                     ((h1 != H1_MAX) || (h0 <= H0_MAX_H20));
  endfunction

endpackage

// File: rtl/bcd_tick_gen.sv
// Fractional phase accumulator producing a registered one-cycle seconds tick.
module bcd_tick_gen
  import bcd_clock_pkg::*;
#(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned INC_0 = 21990,
  parameter int unsigned INC_1 = 1319414,
  parameter int unsigned INC_2 = 79164837,
  parameter int unsigned INC_3 = 79164837
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_speed,
  input  logic       i_run,
  output logic       o_tick
);

  logic [ACC_W-1:0] r_acc;
  logic             r_tick;
  logic [ACC_W-1:0] w_inc;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;

  always_comb begin
    w_inc = ACC_W'(INC_0);
    case (speed_t'(i_speed))
      SPEED_1: w_inc = ACC_W'(INC_1);
      SPEED_2: w_inc = ACC_W'(INC_2);
      SPEED_3: w_inc = ACC_W'(INC_3);
      default: w_inc = ACC_W'(INC_0);
    endcase
  end

  assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, w_inc};

  // The accumulator keeps its phase across speed changes and pauses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else begin
      if (i_run) r_acc <= w_sum;
      r_tick <= i_run & w_carry;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/bcd_clock_reminder.sv
// HH:MM:SS BCD clock with load check, 12/24 h display and optional reminder.
// Optional feature: define WATER_REMIND_EN to build the elapsed-minutes reminder.
module bcd_clock_reminder
  import bcd_clock_pkg::*;
#(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned INC_0 = 21990,
  parameter int unsigned INC_1 = 1319414,
  parameter int unsigned INC_2 = 79164837,
  parameter int unsigned INC_3 = 79164837
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        speed,
  input  logic              run,
  input  logic              hour24,
  input  logic              load,
  input  logic [TIME_W-1:0] load_bcd,
  input  logic [7:0]        remind_min,
  input  logic              remind_ack,
  output logic [TIME_W-1:0] time_bcd,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3,
  output logic [6:0]        hex4,
  output logic [6:0]        hex5,
  output logic              pm,
  output logic              tick,
  output logic              load_err,
  output logic              remind
);

  logic w_tick;

  bcd_tick_gen #(
    .ACC_W(ACC_W), .INC_0(INC_0), .INC_1(INC_1), .INC_2(INC_2), .INC_3(INC_3)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .i_speed(speed),
    .i_run  (run),
    .o_tick (w_tick)
  );

  logic [DIGIT_W-1:0] r_s0, r_s1, r_m0, r_m1, r_h0, r_h1;
  logic               r_load_err;
  logic               w_load_ok;
  logic               w_c_s0, w_c_s1, w_c_m0, w_c_m1, w_hr_wrap;

  assign w_load_ok = bcd_valid_time(load_bcd);
  assign w_c_s0    = (r_s0 == S0_MAX);
  assign w_c_s1    = w_c_s0 && (r_s1 == S1_MAX);
  assign w_c_m0    = w_c_s1 && (r_m0 == M0_MAX);
  assign w_c_m1    = w_c_m0 && (r_m1 == M1_MAX);
  assign w_hr_wrap = (r_h1 == H1_MAX) && (r_h0 == H0_MAX_H20);

  // Digit cascade; a load wins over a same-cycle tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {r_h1, r_h0, r_m1, r_m0, r_s1, r_s0} <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= load & ~w_load_ok;
      if (load) begin
        if (w_load_ok) {r_h1, r_h0, r_m1, r_m0, r_s1, r_s0} <= load_bcd;
      end else if (w_tick) begin
        r_s0 <= w_c_s0 ? '0 : r_s0 + 4'd1;
        if (w_c_s0) r_s1 <= w_c_s1 ? '0 : r_s1 + 4'd1;
        if (w_c_s1) r_m0 <= w_c_m0 ? '0 : r_m0 + 4'd1;
        if (w_c_m0) r_m1 <= w_c_m1 ? '0 : r_m1 + 4'd1;
        if (w_c_m1) begin
          if (w_hr_wrap) begin
            r_h1 <= '0;
            r_h0 <= '0;
          end else if (r_h0 == H0_MAX) begin
            r_h1 <= r_h1 + 4'd1;
            r_h0 <= '0;
          end else begin
            r_h0 <= r_h0 + 4'd1;
          end
        end
      end
    end
  end

  logic [DIGIT_W-1:0] w_disp_h1, w_disp_h0;
  logic               w_pm_hour;

  // 12 h mapping done in BCD: 00 -> 12, 13..19 -> 01..07, 20..23 -> 08..11.
  always_comb begin
    w_pm_hour = (r_h1 == 4'd2) || ((r_h1 == 4'd1) && (r_h0 >= 4'd2));
    w_disp_h1 = r_h1;
    w_disp_h0 = r_h0;
    if (!hour24) begin
      if ({r_h1, r_h0} == 8'h00 || {r_h1, r_h0} == 8'h12) begin
        w_disp_h1 = 4'd1;
        w_disp_h0 = 4'd2;
      end else if (r_h1 == 4'd1 && r_h0 > 4'd2) begin
        w_disp_h1 = 4'd0;
        w_disp_h0 = r_h0 - 4'd2;
      end else if (r_h1 == 4'd2) begin
        w_disp_h1 = (r_h0 < 4'd2) ? 4'd0 : 4'd1;
        w_disp_h0 = (r_h0 < 4'd2) ? r_h0 + 4'd8 : r_h0 - 4'd2;
      end
    end
  end

  assign time_bcd = {r_h1, r_h0, r_m1, r_m0, r_s1, r_s0};
  assign hex0     = seg7(r_s0);
  assign hex1     = seg7(r_s1);
  assign hex2     = seg7(r_m0);
  assign hex3     = seg7(r_m1);
  assign hex4     = seg7(w_disp_h0);
  assign hex5     = seg7(w_disp_h1);
  assign pm       = ~hour24 & w_pm_hour;
  assign tick     = w_tick;
  assign load_err = r_load_err;

`ifdef WATER_REMIND_EN
  logic [DIGIT_W-1:0] r_e0, r_e1;
  logic               r_remind;
  logic [DIGIT_W-1:0] w_e0_nx, w_e1_nx;
  logic               w_rollover, w_match;

  assign w_rollover = w_tick & ~load & w_c_s1;
  assign w_e0_nx    = (r_e0 == 4'd9) ? '0 : r_e0 + 4'd1;
  assign w_e1_nx    = (r_e0 != 4'd9) ? r_e1 : ((r_e1 == 4'd9) ? '0 : r_e1 + 4'd1);
  assign w_match    = (remind_min != 8'h00) && ({w_e1_nx, w_e0_nx} == remind_min);

  // Elapsed-minutes counter; ack beats a match, a valid load only restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e0     <= '0;
      r_e1     <= '0;
      r_remind <= 1'b0;
    end else if (remind_ack) begin
      r_e0     <= '0;
      r_e1     <= '0;
      r_remind <= 1'b0;
    end else if (load && w_load_ok) begin
      r_e0 <= '0;
      r_e1 <= '0;
    end else if (w_rollover) begin
      if (w_match) begin
        r_remind <= 1'b1;
        r_e0     <= '0;
        r_e1     <= '0;
      end else begin
        r_e0 <= w_e0_nx;
        r_e1 <= w_e1_nx;
      end
    end
  end

  assign remind = r_remind;
`else
  logic w_unused_remind;
  assign w_unused_remind = ^{remind_min, remind_ack};
  assign remind          = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_clock_reminder.sv
// Scoreboard bench: a seconds-count reference model queues per-cycle expectations, a monitor checks them.
module tb_bcd_clock_reminder;

  localparam int ACC_B = 8;
  localparam int INC_B = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  speed;
  logic        run, hour24, load, remind_ack;
  logic [23:0] load_bcd;
  logic [7:0]  remind_min;
  logic [23:0] time_bcd;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        pm, tick, load_err, remind;

  bcd_clock_reminder #(
    .ACC_W(ACC_B), .INC_0(INC_B), .INC_1(INC_B), .INC_2(INC_B), .INC_3(INC_B)
  ) dut (
    .clk(clk), .reset(reset), .speed(speed), .run(run), .hour24(hour24),
    .load(load), .load_bcd(load_bcd), .remind_min(remind_min), .remind_ack(remind_ack),
    .time_bcd(time_bcd), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .hex4(hex4), .hex5(hex5), .pm(pm), .tick(tick), .load_err(load_err), .remind(remind)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] t;
    logic        tck;
    logic        lerr;
    logic        rem;
    logic [41:0] hex;
    logic        pm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference state: time as seconds since midnight, accumulator as an integer.
  int m_acc, m_secs, m_elapsed;
  bit m_tick, m_lerr, m_remind;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [23:0] enc(input int secs);
    int hh, mm, ss;
    hh = secs / 3600; mm = (secs / 60) % 60; ss = secs % 60;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic bit decode_time(input logic [23:0] b, output int secs);
    bit ok;
    int hh, mm, ss;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    hh = int'(b[23:20]) * 10 + int'(b[19:16]);
    mm = int'(b[15:12]) * 10 + int'(b[11:8]);
    ss = int'(b[7:4]) * 10 + int'(b[3:0]);
    if (hh > 23 || mm > 59 || ss > 59) ok = 1'b0;
    secs = hh * 3600 + mm * 60 + ss;
    return ok;
  endfunction

  task automatic model_push();
    exp_t e;
    int hh, dh, mm, ss;
    hh = m_secs / 3600; mm = (m_secs / 60) % 60; ss = m_secs % 60;
    dh = hour24 ? hh : ((hh % 12 == 0) ? 12 : hh % 12);
    e.t    = enc(m_secs);
    e.tck  = m_tick;
    e.lerr = m_lerr;
    e.rem  = m_remind;
    e.hex  = {seg(dh / 10), seg(dh % 10), seg(mm / 10), seg(mm % 10), seg(ss / 10), seg(ss % 10)};
    e.pm   = !hour24 && hh >= 12;
    q.push_back(e);
  endtask

  // Advance the model by one clock with the current inputs, queue the expectation, wait a cycle.
  task automatic cyc();
    int  ld_secs, nsecs;
    bit  ok, roll;
    if (reset) begin
      m_acc = 0; m_secs = 0; m_elapsed = 0; m_tick = 0; m_lerr = 0; m_remind = 0;
    end else begin
      ok    = decode_time(load_bcd, ld_secs);
      roll  = m_tick && !load && (m_secs % 60 == 59);
      nsecs = load ? (ok ? ld_secs : m_secs) : (m_tick ? (m_secs + 1) % 86400 : m_secs);
`ifdef WATER_REMIND_EN
      if (remind_ack) begin
        m_elapsed = 0; m_remind = 0;
      end else if (load && ok) begin
        m_elapsed = 0;
      end else if (roll) begin
        m_elapsed = (m_elapsed + 1) % 100;
        if (remind_min != 8'h00 &&
            m_elapsed == int'(remind_min[7:4]) * 10 + int'(remind_min[3:0])) begin
          m_remind = 1; m_elapsed = 0;
        end
      end
`endif
      m_lerr = load && !ok;
      if (run) begin
        m_tick = (m_acc + INC_B) >= (1 << ACC_B);
        m_acc  = (m_acc + INC_B) % (1 << ACC_B);
      end else begin
        m_tick = 0;
      end
      m_secs = nsecs;
    end
    model_push();
    @(negedge clk); #1;
    load = 1'b0;
    remind_ack = 1'b0;
  endtask

  task automatic do_load(input logic [23:0] v);
    load = 1'b1;
    load_bcd = v;
    cyc();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a new state, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("time_bcd", 64'(time_bcd), 64'(e.t));
        chk("tick", 64'(tick), 64'(e.tck));
        chk("load_err", 64'(load_err), 64'(e.lerr));
        chk("remind", 64'(remind), 64'(e.rem));
        chk("hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(e.hex));
        chk("pm", 64'(pm), 64'(e.pm));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    reset = 1'b1; speed = 2'd0; run = 1'b0; hour24 = 1'b1; load = 1'b0;
    load_bcd = '0; remind_min = 8'h00; remind_ack = 1'b0;
    @(negedge clk); #1;
    cyc(); cyc();
    reset = 1'b0;

    run = 1'b1;
    repeat (10) cyc();

    do_load(24'h235958);
    repeat (6) cyc();

    hour24 = 1'b0;
    do_load(24'h130500);
    repeat (3) cyc();
    do_load(24'h000000);
    repeat (3) cyc();
    do_load(24'h225911);
    repeat (3) cyc();
    hour24 = 1'b1;

    do_load(24'h250000);
    cyc();
    do_load(24'h006000);
    cyc();

    // Load landing on the same edge as a tick.
    for (int k = 0; k < 4 && !m_tick; k++) cyc();
    do_load(24'h101010);
    repeat (3) cyc();

    // Asynchronous reset in the middle of counting.
    repeat (5) cyc();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    repeat (4) cyc();

    // Reminder every two minutes, acknowledged a few cycles after each rise.
    remind_min = 8'h02;
    do_load(24'h000000);
    hold = 0;
    for (int i = 0; i < 1100; i++) begin
      if (m_remind) begin
        if (hold == 3) begin
          remind_ack = 1'b1;
          hold = 0;
        end else begin
          hold++;
        end
      end
      cyc();
    end

    // Randomized run/speed/format/load/ack traffic.
    for (int i = 0; i < 3000; i++) begin
      run    = ($urandom % 8) != 0;
      speed  = 2'($urandom % 4);
      hour24 = ($urandom % 4) != 0;
      if ($urandom % 200 == 0) remind_min = 8'($urandom % 4);
      if ($urandom % 60 == 0) remind_ack = 1'b1;
      if ($urandom % 25 == 0) begin
        load = 1'b1;
        if ($urandom % 3 == 0)
          load_bcd = 24'($urandom);
        else
          load_bcd = enc(($urandom % 24) * 3600 + $urandom_range(58, 59) * 60 + $urandom_range(50, 59));
      end
      cyc();
    end

    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
